// File: rtl/rtc_access_sequencer.sv
// Bus sequencer for a multiplexed address/data RTC: arbitrates a read-burst engine and a
// single-register write port, and times each access as ADDR, GAP1, DATA and GAP2 phases.
module rtc_access_sequencer #(
  parameter int T_PH  = 8,
  parameter int T_GAP = 11,
  parameter int NREG  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_start,
  input  logic [7:0] rd_base,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic [3:0] rd_idx,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam int CMAX = (T_PH > T_GAP) ? T_PH : T_GAP;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] PH_LAST   = CW'(T_PH - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(T_GAP - 1);
  localparam logic [CW-1:0] STRB_LAST = CW'(T_PH - 2);
  localparam logic [CW-1:0] STRB_FRST = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_pend, w_pend_nxt;
  logic [3:0]    r_bidx, w_bidx_nxt;
  logic [7:0]    r_base, w_base_nxt;
  logic          r_is_wr, w_is_wr_nxt;
  logic [7:0]    r_addr, w_addr_nxt;
  logic [7:0]    r_wdata, w_wdata_nxt;
  logic [7:0]    r_rbuf, w_rbuf_nxt;

  logic          r_cs_n, r_rd_n, r_wr_n, r_a_d, r_ad_oe;
  logic [7:0]    r_ad_out;
  logic          r_rd_valid, r_wr_ack, r_busy;
  logic [7:0]    r_rd_data;
  logic [3:0]    r_rd_idx;

  logic          w_cs_n_nxt, w_rd_n_nxt, w_wr_n_nxt, w_a_d_nxt, w_ad_oe_nxt;
  logic [7:0]    w_ad_out_nxt;
  logic          w_rd_valid_nxt, w_wr_ack_nxt, w_busy_nxt;
  logic [7:0]    w_rd_data_nxt;
  logic [3:0]    w_rd_idx_nxt;
  logic          w_strb_win;

  // Outputs are computed from the next state so the registered pins line up with r_state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_pend_nxt  = r_pend;
    w_bidx_nxt  = r_bidx;
    w_base_nxt  = r_base;
    w_is_wr_nxt = r_is_wr;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rbuf_nxt  = r_rbuf;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (wr_req) begin
          w_state_nxt = S_ADDR;
          w_is_wr_nxt = 1'b1;
          w_addr_nxt  = wr_addr;
          w_wdata_nxt = wr_data;
        end else if (r_pend != '0) begin
          w_state_nxt = S_ADDR;
          w_is_wr_nxt = 1'b0;
          w_addr_nxt  = r_base + {4'b0000, r_bidx};
        end
      end
      S_ADDR: if (r_cnt == PH_LAST)  begin w_state_nxt = S_GAP1; w_cnt_nxt = '0; end
      S_GAP1: if (r_cnt == GAP_LAST) begin w_state_nxt = S_DATA; w_cnt_nxt = '0; end
      S_DATA: if (r_cnt == PH_LAST)  begin w_state_nxt = S_GAP2; w_cnt_nxt = '0; end
      S_GAP2: if (r_cnt == GAP_LAST) begin w_state_nxt = S_IDLE; w_cnt_nxt = '0; end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (r_state == S_DATA && !r_is_wr && r_cnt == STRB_LAST)
      w_rbuf_nxt = ad_in;

    // A delivered read retires one pending entry; a new burst can only load an empty counter.
    if (r_rd_valid) begin
      w_pend_nxt = r_pend - 1'b1;
      w_bidx_nxt = r_bidx + 1'b1;
    end else if (rd_start && r_pend == '0) begin
      w_pend_nxt = 4'(NREG);
      w_bidx_nxt = '0;
      w_base_nxt = rd_base;
    end

    w_strb_win   = (w_cnt_nxt >= STRB_FRST) && (w_cnt_nxt <= STRB_LAST);
    w_cs_n_nxt   = !(w_state_nxt == S_ADDR || w_state_nxt == S_DATA);
    w_a_d_nxt    = (w_state_nxt != S_ADDR);
    w_wr_n_nxt   = !(w_strb_win && (w_state_nxt == S_ADDR ||
                                    (w_state_nxt == S_DATA && w_is_wr_nxt)));
    w_rd_n_nxt   = !(w_strb_win && w_state_nxt == S_DATA && !w_is_wr_nxt);
    w_ad_oe_nxt  = (w_state_nxt == S_ADDR) || (w_state_nxt == S_DATA && w_is_wr_nxt);
    w_ad_out_nxt = 8'h00;
    if (w_state_nxt == S_ADDR)
      w_ad_out_nxt = w_addr_nxt;
    else if (w_state_nxt == S_DATA && w_is_wr_nxt)
      w_ad_out_nxt = w_wdata_nxt;

    w_rd_valid_nxt = (r_state == S_DATA) && (w_state_nxt == S_GAP2) && !r_is_wr;
    w_rd_data_nxt  = w_rd_valid_nxt ? r_rbuf : r_rd_data;
    w_rd_idx_nxt   = w_rd_valid_nxt ? r_bidx : r_rd_idx;
    w_wr_ack_nxt   = (w_state_nxt == S_GAP2) && (w_cnt_nxt == GAP_LAST) && w_is_wr_nxt;
    w_busy_nxt     = (w_state_nxt != S_IDLE) || (w_pend_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pend     <= '0;
      r_bidx     <= '0;
      r_base     <= '0;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rbuf     <= '0;
      r_cs_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_a_d      <= 1'b1;
      r_ad_oe    <= 1'b0;
      r_ad_out   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_idx   <= '0;
      r_wr_ack   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_bidx     <= w_bidx_nxt;
      r_base     <= w_base_nxt;
      r_is_wr    <= w_is_wr_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rbuf     <= w_rbuf_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_rd_n     <= w_rd_n_nxt;
      r_wr_n     <= w_wr_n_nxt;
      r_a_d      <= w_a_d_nxt;
      r_ad_oe    <= w_ad_oe_nxt;
      r_ad_out   <= w_ad_out_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_idx   <= w_rd_idx_nxt;
      r_wr_ack   <= w_wr_ack_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign cs_n     = r_cs_n;
  assign rd_n     = r_rd_n;
  assign wr_n     = r_wr_n;
  assign a_d      = r_a_d;
  assign ad_oe    = r_ad_oe;
  assign ad_out   = r_ad_out;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_idx   = r_rd_idx;
  assign wr_ack   = r_wr_ack;
  assign busy     = r_busy;

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Self-checking bench for rtc_access_sequencer: an RTC bus model, per-access timing monitor,
// read/write scoreboards, a table of accesses and hand-written arbitration/reset sequences.
module tb_rtc_access_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd_start;
  logic [7:0] rd_base;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [3:0] rd_idx;
  logic       wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       wr_ack, busy;
  logic       cs_n, rd_n, wr_n, a_d;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  always #5 clk = ~clk;

  rtc_access_sequencer #(.T_PH(8), .T_GAP(11), .NREG(3)) dut (
    .clk(clk), .reset(reset),
    .rd_start(rd_start), .rd_base(rd_base),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] idx;
  } exp_t;

  typedef struct packed {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] d0, d1, d2;
  } vec_t;

  exp_t       rd_q[$];
  exp_t       wr_q[$];
  int         rd_cycs[$];
  logic [7:0] rtc_mem [256];
  logic [7:0] mon_addr = 8'h00;
  logic [7:0] mon_wdata = 8'h00;
  logic       prev_cs_n = 1'b1;
  int         cyc = 0, acc_start = 0, addr_strb = 0, data_strb = 0, last_rd_cyc = 0;
  string      ev = "";
  int         n_checks = 0, n_fail = 0;
  vec_t       vecs [6];
  vec_t       v;
  logic [7:0] a1, a2;

  // RTC model: returns the register latched during the address phase while rd_n is low.
  assign ad_in = (!cs_n && a_d && !rd_n) ? rtc_mem[mon_addr] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample on the falling edge, run the bus checker and the scoreboards.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    check("bus_rules", {31'd0, !((!rd_n || !wr_n) && cs_n) && !(!rd_n && !wr_n) &&
                               !(!rd_n && ad_oe)}, 32'd1);
    if (!cs_n && !a_d && prev_cs_n) begin
      acc_start = cyc;
      addr_strb = 0;
      data_strb = 0;
    end
    if (!cs_n && !a_d && !wr_n) begin
      mon_addr = ad_out;
      addr_strb++;
    end
    if (!cs_n && a_d && !wr_n) begin
      mon_wdata = ad_out;
      data_strb++;
    end
    if (!cs_n && a_d && !rd_n) data_strb++;
    prev_cs_n = cs_n;

    if (rd_valid) begin
      ev = {ev, "R"};
      rd_cycs.push_back(cyc);
      last_rd_cyc = cyc;
      check("rd_valid_expected", {31'd0, rd_q.size() > 0}, 32'd1);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_idx", rd_idx, e.idx);
        check("rd_bus_addr", mon_addr, e.addr);
        check("rd_addr_strobe_len", addr_strb, 6);
        check("rd_data_strobe_len", data_strb, 6);
        check("rd_valid_latency", cyc - acc_start, 27);
      end
    end
    if (wr_ack) begin
      ev = {ev, "W"};
      check("wr_ack_expected", {31'd0, wr_q.size() > 0}, 32'd1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        check("wr_bus_addr", mon_addr, e.addr);
        check("wr_bus_data", mon_wdata, e.data);
        check("wr_addr_strobe_len", addr_strb, 6);
        check("wr_data_strobe_len", data_strb, 6);
        check("wr_ack_latency", cyc - acc_start, 37);
      end
    end
  endtask

  // what: 0 = wr_ack high, 1 = busy low, 2 = DATA phase on the bus.
  task automatic wait_for(input int what, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((what == 0 && wr_ack) || (what == 1 && !busy) || (what == 2 && !cs_n && a_d))
        return;
    end
    check(name, 32'd0, 32'd1);
  endtask

  task automatic push_burst(input logic [7:0] base, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] b1, b2;
    b1 = base + 8'd1;
    b2 = base + 8'd2;
    rtc_mem[base] = d0;
    rtc_mem[b1]   = d1;
    rtc_mem[b2]   = d2;
    rd_q.push_back('{base, d0, 4'd0});
    rd_q.push_back('{b1, d1, 4'd1});
    rd_q.push_back('{b2, d2, 4'd2});
  endtask

  task automatic queues_drained(input string name);
    check({name, "_rd_q_empty"}, rd_q.size(), 0);
    check({name, "_wr_q_empty"}, wr_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h21, 8'h59, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h21, 8'h10, 8'h20, 8'h30};
    vecs[2] = '{1'b1, 8'h00, 8'hA5, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 8'hFF, 8'h11, 8'h22, 8'h33};
    vecs[4] = '{1'b0, 8'h7E, 8'hC1, 8'h5A, 8'h0F};
    vecs[5] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};

    for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
    reset = 1'b0;
    rd_start = 1'b0;
    rd_base = 8'h00;
    wr_req = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    repeat (3) tick();

    check("rst_cs_n", cs_n, 1);
    check("rst_rd_n", rd_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_a_d", a_d, 1);
    check("rst_ad_oe", ad_oe, 0);
    check("rst_ad_out", ad_out, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_idx", rd_idx, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_busy", busy, 0);

    reset = 1'b1;
    repeat (2) tick();

    // Table of single writes and full bursts.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      ev = "";
      rd_cycs.delete();
      if (v.is_wr) begin
        wr_addr = v.addr;
        wr_data = v.d0;
        wr_req  = 1'b1;
        wr_q.push_back('{v.addr, v.d0, 4'd0});
        wait_for(0, 200, "wr_ack_timeout");
        wr_req = 1'b0;
        repeat (3) tick();
        check("wr_busy_after", busy, 0);
      end else begin
        push_burst(v.addr, v.d0, v.d1, v.d2);
        rd_base  = v.addr;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("busy_after_start", busy, 1);
        wait_for(1, 300, "burst_timeout");
        check("busy_fall_delay", cyc - last_rd_cyc, 11);
        check("burst_len", rd_cycs.size(), 3);
        if (rd_cycs.size() == 3) begin
          check("rd_spacing_01", rd_cycs[1] - rd_cycs[0], 39);
          check("rd_spacing_12", rd_cycs[2] - rd_cycs[1], 39);
        end
        repeat (3) tick();
      end
      queues_drained("vec");
    end

    // Simultaneous write request and burst start: the write goes first.
    ev = "";
    push_burst(8'h50, 8'h01, 8'h02, 8'h03);
    wr_q.push_back('{8'h40, 8'h77, 4'd0});
    wr_addr = 8'h40;
    wr_data = 8'h77;
    wr_req = 1'b1;
    rd_base = 8'h50;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_for(0, 200, "simul_wr_timeout");
    wr_req = 1'b0;
    wait_for(1, 300, "simul_burst_timeout");
    repeat (3) tick();
    check($sformatf("simul_order_%s", ev), {31'd0, ev == "WRRR"}, 32'd1);
    queues_drained("simul");

    // Write raised during read #0 is served between reads without cutting any access short.
    ev = "";
    rd_cycs.delete();
    push_burst(8'h30, 8'hAA, 8'hBB, 8'hCC);
    rd_base = 8'h30;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (10) tick();
    wr_q.push_back('{8'h05, 8'hC3, 4'd0});
    wr_addr = 8'h05;
    wr_data = 8'hC3;
    wr_req = 1'b1;
    wait_for(0, 300, "mid_wr_timeout");
    wr_req = 1'b0;
    wait_for(1, 300, "mid_burst_timeout");
    repeat (3) tick();
    check($sformatf("mid_order_%s", ev), {31'd0, ev == "RWRR"}, 32'd1);
    if (rd_cycs.size() == 3) begin
      check("mid_rd_spacing_01", rd_cycs[1] - rd_cycs[0], 78);
      check("mid_rd_spacing_12", rd_cycs[2] - rd_cycs[1], 39);
    end
    queues_drained("mid");

    // rd_start while a burst is pending is ignored.
    ev = "";
    push_burst(8'h60, 8'h61, 8'h62, 8'h63);
    rtc_mem[8'h90] = 8'hEE;
    rd_base = 8'h60;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (50) tick();
    rd_base = 8'h90;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_for(1, 300, "ignore_burst_timeout");
    repeat (120) tick();
    check($sformatf("ignore_order_%s", ev), {31'd0, ev == "RRR"}, 32'd1);
    queues_drained("ignore");

    // Reset during a write DATA phase aborts it: strobes released at once, no wr_ack.
    ev = "";
    wr_addr = 8'h12;
    wr_data = 8'h34;
    wr_req = 1'b1;
    wait_for(2, 100, "abort_data_timeout");
    repeat (2) tick();
    check("abort_wr_n_low_before", wr_n, 0);
    #2 reset = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_wr_n", wr_n, 1);
    check("abort_rd_n", rd_n, 1);
    check("abort_ad_oe", ad_oe, 0);
    check("abort_busy", busy, 0);
    wr_req = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (60) tick();
    check("abort_idle_cs_n", cs_n, 1);
    check("abort_idle_busy", busy, 0);
    check($sformatf("abort_events_%s", ev), {31'd0, ev == ""}, 32'd1);
    queues_drained("abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
